uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares one UART transmitter byte interface among NREQ message sources (e.g. core console, boot-status reporter, debug monitor). A granted source is locked until it completes a message, exhausts its burst budget or stalls, so messages from different sources never interleave on the line. The block sits between the requesters and the UART transmit core's valid/ready byte port, adding one output register stage.

## Interface
- NREQ, 4: number of requesters (2..8)
- BURST_MAX, 64: maximum bytes per grant (1..255)
- IDLE_TO, 255: consecutive cycles with req_valid low before a locked grant is revoked (1..65535)

- mclk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_en  in  1  1 = new grants allowed; 0 = no new grants (current lock runs to release)
- req_valid  in  NREQ  byte valid per requester
- req_data  in  8*NREQ  byte per requester, requester i at [8*i+7:8*i]
- req_last  in  NREQ  byte is last of message
- req_ready  out  NREQ  byte accepted (only granted bit can be 1)
- tx_valid  out  1  byte valid to UART TX core
- tx_data  out  8  byte to UART TX core
- tx_ready  in  1  UART TX core accepts byte
- grant_vld  out  1  a requester is locked
- grant_id  out  clog2(NREQ)  locked requester index
- to_pulse  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- FSM states: IDLE, LOCK.
- IDLE: if cfg_en and any req_valid, pick first valid index searching from (last_id+1) mod NREQ upward with wrap; register grant_id, set grant_vld, go LOCK. No bytes transferred in IDLE.
- LOCK: req_ready[grant_id] = !tx_valid || tx_ready; all other req_ready = 0. Accepted byte (req_valid & req_ready) loads tx_data, sets tx_valid; burst_cnt += 1; idle counter cleared.
- Output register: tx_valid clears when tx_ready and no new byte loads the same cycle.
- Release (LOCK -> IDLE, grant_vld = 0, last_id = grant_id) on any of: accepted byte with req_last; accepted byte making burst_cnt == BURST_MAX; idle counter reaching IDLE_TO (to_pulse = 1). Simultaneous last and burst-max: single release. Released byte still sits in tx register and drains normally.
- burst_cnt and idle counter cleared on entry to LOCK. Idle counter increments each LOCK cycle with req_valid[grant_id] = 0; holds when req_valid = 1 but tx path stalled (back-pressure is not a timeout).
- cfg_en deasserted in LOCK has no effect on the current grant.
- Requester dropping req_valid without last: normal; lock held until timeout.
- NREQ requests all asserted continuously: each gets one grant in turn, strict rotation.

## Timing
- Reset values: tx_valid 0, tx_data 0, req_ready 0, grant_vld 0, grant_id 0, to_pulse 0, state IDLE, last_id NREQ-1 (first priority to requester 0), counters 0.
- Reset mid-operation: all state cleared immediately; buffered byte dropped; tx_valid low asynchronously.
- Arbitration: request seen in IDLE at cycle N -> grant_vld high N+1 -> first req_ready possible N+1.
- Data latency: byte accepted at cycle N -> tx_valid/tx_data at N+1.
- Throughput: one byte per cycle while tx_ready held high.
- Release at cycle N -> IDLE at N+1 -> next grant at N+2 (one dead cycle per hand-over).
- req_ready combinationally depends on tx_ready; no other input-to-output combinational paths.

## Structure
- Shared package uart_pkg: FSM state encoding (ST_IDLE, ST_LOCK), default BURST_MAX/IDLE_TO constants.
- One sub-module: uart_rr_pick — combinational round-robin first-one search (inputs req vector, last_id; outputs found, idx).
- Counters: burst_cnt 8 bits, idle counter 16 bits, saturating compares only.

## Test plan
- Single source: req 0 sends 0x48,0x69,0x0A (last on 0x0A), tx_ready = 1 -> tx_data 0x48,0x69,0x0A on consecutive cycles, grant released after 0x0A, grant_vld low next cycle.
- Rotation: req 0..3 all valid, each message 2 bytes -> grant_id sequence 0,1,2,3,0; no bytes of different ids interleaved.
- Burst limit BURST_MAX=4: req 1 sends 10 bytes without last, req 2 also valid -> grants 1(4 bytes),2,1(4),2,1(2).
- Timeout IDLE_TO=8: req 3 sends 1 byte then drops valid -> to_pulse exactly 8 cycles later, grant released; with tx_ready low and req_valid high for 20 cycles -> no to_pulse.
- Back-pressure: tx_ready toggled 1/0 pseudo-randomly during 16-byte message -> all 16 bytes delivered in order, no duplicate/loss.
- Reset in LOCK with tx_valid high -> all outputs reset values next edge; after release of reset, requester 0 granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// limits, counter widths and the grant-index width helper.
package uart_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned BURST_MAX_DEF = 64;
    localparam int unsigned IDLE_TO_DEF   = 255;
    localparam int unsigned BURST_CNT_W   = 8;
    localparam int unsigned IDLE_CNT_W    = 16;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin first-one search.
// Ports:
//   req_i      - request vector, one bit per requester
//   last_id_i  - index that was served last (lowest priority this round)
//   found_o    - at least one request bit is set
//   idx_o      - first set index searching upward from last_id_i+1 with wrap
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_id_i,
    output logic            found_o,
    output logic [IDW-1:0]  idx_o
);

    // Walk from lowest priority (offset NREQ == last_id) to highest
    // (offset 1) so the last hit written is the winner.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(last_id_i) + NREQ - k) % NREQ;
            if (req_i[IDW'(cand)]) begin
                found_o = 1'b1;
                idx_o   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX byte port among NREQ sources.
// A grant stays locked until the source ends a message, uses up its burst
// budget or goes quiet for IDLE_TO cycles, so messages never interleave.
// Ports:
//   mclk, reset_n   - clock, asynchronous active-low reset
//   cfg_en          - allow new grants (an existing lock always runs out)
//   req_valid/data/last/ready - per-requester byte handshake (req_ready is
//                     combinational on tx_ready)
//   tx_valid/data/ready - registered byte port towards the UART TX core
//   grant_vld/grant_id  - current lock and owner
//   to_pulse        - one-cycle pulse when a lock is revoked by timeout
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    parameter int unsigned IDLE_TO   = IDLE_TO_DEF,
    parameter int unsigned IDW       = id_width(NREQ)
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              cfg_en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              grant_vld,
    output logic [IDW-1:0]    grant_id,
    output logic              to_pulse
);

    arb_state_e             state_q, state_d;
    logic [IDW-1:0]         gid_q, gid_d;
    logic [IDW-1:0]         last_id_q, last_id_d;
    logic                   gvld_q, gvld_d;
    logic [BURST_CNT_W-1:0] burst_q, burst_d;
    logic [IDLE_CNT_W-1:0]  idle_q, idle_d;
    logic                   txv_q, txv_d;
    logic [7:0]             txd_q, txd_d;
    logic                   to_q, to_d;

    logic                   pick_found;
    logic [IDW-1:0]         pick_idx;
    logic                   slot_free;
    logic                   sel_valid;
    logic                   sel_last;
    logic [7:0]             sel_data;
    logic                   accept;
    logic [BURST_CNT_W:0]   burst_inc;
    logic [IDLE_CNT_W:0]    idle_inc;
    logic                   burst_hit;
    logic                   idle_hit;

    uart_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i     (req_valid),
        .last_id_i (last_id_q),
        .found_o   (pick_found),
        .idx_o     (pick_idx)
    );

    // Granted source's byte and handshake qualifiers.
    assign slot_free = !txv_q || tx_ready;
    assign sel_valid = req_valid[gid_q];
    assign sel_last  = req_last[gid_q];
    assign sel_data  = req_data[32'(gid_q)*8 +: 8];
    assign accept    = (state_q == ST_LOCK) && sel_valid && slot_free;

    // Counters are compared one bit wider so they never wrap silently.
    assign burst_inc = (BURST_CNT_W+1)'(burst_q) + (BURST_CNT_W+1)'(1);
    assign idle_inc  = (IDLE_CNT_W+1)'(idle_q) + (IDLE_CNT_W+1)'(1);
    assign burst_hit = burst_inc >= (BURST_CNT_W+1)'(BURST_MAX);
    assign idle_hit  = idle_inc >= (IDLE_CNT_W+1)'(IDLE_TO);

    // Only the locked source may see ready, and only when the output slot frees.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_LOCK && slot_free) begin
            req_ready[gid_q] = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        last_id_d = last_id_q;
        gvld_d    = gvld_q;
        burst_d   = burst_q;
        idle_d    = idle_q;
        txv_d     = txv_q;
        txd_d     = txd_q;
        to_d      = 1'b0;

        // Output register: a new byte wins over draining the old one.
        if (accept) begin
            txv_d = 1'b1;
            txd_d = sel_data;
        end else if (tx_ready) begin
            txv_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_en && pick_found) begin
                    state_d = ST_LOCK;
                    gvld_d  = 1'b1;
                    gid_d   = pick_idx;
                    burst_d = '0;
                    idle_d  = '0;
                end
            end
            ST_LOCK: begin
                if (accept) begin
                    burst_d = BURST_CNT_W'(burst_inc);
                    idle_d  = '0;
                    if (sel_last || burst_hit) begin
                        state_d   = ST_IDLE;
                        gvld_d    = 1'b0;
                        last_id_d = gid_q;
                    end
                end else if (!sel_valid) begin
                    // A stalled tx path with valid held is not idleness.
                    if (idle_hit) begin
                        state_d   = ST_IDLE;
                        gvld_d    = 1'b0;
                        last_id_d = gid_q;
                        to_d      = 1'b1;
                    end else begin
                        idle_d = IDLE_CNT_W'(idle_inc);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gvld_d  = 1'b0;
            end
        endcase
    end

    // State register; reset drops any buffered byte.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gid_q     <= '0;
            last_id_q <= IDW'(NREQ - 1);
            gvld_q    <= 1'b0;
            burst_q   <= '0;
            idle_q    <= '0;
            txv_q     <= 1'b0;
            txd_q     <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gid_q     <= gid_d;
            last_id_q <= last_id_d;
            gvld_q    <= gvld_d;
            burst_q   <= burst_d;
            idle_q    <= idle_d;
            txv_q     <= txv_d;
            txd_q     <= txd_d;
            to_q      <= to_d;
        end
    end

    assign tx_valid  = txv_q;
    assign tx_data   = txd_q;
    assign grant_vld = gvld_q;
    assign grant_id  = gid_q;
    assign to_pulse  = to_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb (NREQ=4, BURST_MAX=4, IDLE_TO=8).
module tb_uart_tx_arb;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned BURST_MAX = 4;
    localparam int unsigned IDLE_TO   = 8;
    localparam int unsigned IDW       = 2;

    logic              mclk = 1'b0;
    logic              reset_n;
    logic              cfg_en;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              grant_vld;
    logic [IDW-1:0]    grant_id;
    logic              to_pulse;

    always #5 mclk = ~mclk;

    uart_tx_arb #(
        .NREQ      (NREQ),
        .BURST_MAX (BURST_MAX),
        .IDLE_TO   (IDLE_TO)
    ) dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .cfg_en    (cfg_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .to_pulse  (to_pulse)
    );

    logic [7:0]  src_d [NREQ][$];
    bit          src_l [NREQ][$];
    logic [7:0]  exp_q [$];
    int          gexp_q [$];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int          tx_mode    = 0;
    int          cyc        = 0;
    int          burst_m    = 0;
    int          to_cnt     = 0;
    int          to_cyc     = 0;
    int          acc_cyc    = 0;
    int          tx_first   = 0;
    int          tx_last    = 0;
    int          tx_hs_n    = 0;
    bit          p_acc, p_rel, p_arb, p_gvld;
    logic [7:0]  p_acc_data;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int id, input int n, input logic [7:0] base, input bit last_end);
        for (int k = 0; k < n; k++) begin
            src_d[id].push_back(base + 8'(k));
            src_l[id].push_back(last_end && (k == n - 1));
        end
    endtask

    task automatic expect_bytes(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(base + 8'(k));
    endtask

    function automatic int pending();
        int s;
        s = exp_q.size() + gexp_q.size();
        for (int i = 0; i < NREQ; i++) s += src_d[i].size();
        return s;
    endfunction

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            src_d[i].delete();
            src_l[i].delete();
        end
        exp_q.delete();
        gexp_q.delete();
        p_acc = 0; p_rel = 0; p_arb = 0; p_gvld = 0;
        burst_m = 0; to_cnt = 0; tx_hs_n = 0;
        req_valid = '0; req_data = '0; req_last = '0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_d[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_d[i][0];
                req_last[i]        = src_l[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        case (tx_mode)
            1:       tx_ready = 1'b0;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b1;
        endcase
    endtask

    // One clock: drive at negedge, sample just before the posedge.
    task automatic cycle();
        @(negedge mclk);
        drive_inputs();
        #1;
        cyc++;
        if (p_acc) begin
            check("lat_valid", 32'(tx_valid), 1);
            check("lat_data", 32'(tx_data), 32'(p_acc_data));
        end
        if (p_rel) check("release", 32'(grant_vld), 0);
        if (p_arb) check("arb_lat", 32'(grant_vld), 1);
        if (!grant_vld) check("rdy_idle", 32'(req_ready), 0);
        if (grant_vld && !p_gvld) begin
            burst_m = 0;
            if (gexp_q.size() == 0) check("grant_extra", 32'(gexp_q.size()), 1);
            else check("grant_id", 32'(grant_id), 32'(gexp_q.pop_front()));
        end
        if (tx_valid && tx_ready) begin
            if (tx_hs_n == 0) tx_first = cyc;
            tx_last = cyc;
            tx_hs_n++;
            if (exp_q.size() == 0) check("tx_extra", 32'(exp_q.size()), 1);
            else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        if (to_pulse) begin
            to_cnt++;
            to_cyc = cyc;
        end
        p_acc = 0;
        p_rel = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                p_acc      = 1;
                p_acc_data = src_d[i][0];
                burst_m++;
                p_rel      = src_l[i][0] || (burst_m == int'(BURST_MAX));
                acc_cyc    = cyc;
                void'(src_d[i].pop_front());
                void'(src_l[i].pop_front());
            end
        end
        p_arb  = !grant_vld && cfg_en && (req_valid != '0);
        p_gvld = grant_vld;
        @(posedge mclk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        while (left > 0 && !(pending() == 0 && !grant_vld)) begin
            cycle();
            left--;
        end
        run(2);
        check("drain_pending", 32'(pending()), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush();
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
    endtask

    task automatic check_reset_vals();
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_grant_vld", 32'(grant_vld), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_to_pulse", 32'(to_pulse), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b1;
        cfg_en   = 1'b0;
        tx_ready = 1'b1;
        flush();
        #1 reset_n = 1'b0;
        #10;
        check_reset_vals();
        @(negedge mclk);
        reset_n = 1'b1;

        // Single source "Hi\n", first held off by cfg_en.
        send(0, 1, 8'h48, 0);
        send(0, 1, 8'h69, 0);
        send(0, 1, 8'h0A, 1);
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h0A);
        gexp_q.push_back(0);
        run(3);
        check("cfg_block", 32'(grant_vld), 0);
        cfg_en = 1'b1;
        drain(50);
        check("single_bytes", 32'(tx_hs_n), 3);
        check("single_back2back", 32'(tx_last - tx_first), 2);

        // Rotation over all four sources, 2-byte messages.
        do_reset();
        send(0, 2, 8'h00, 1);
        send(0, 2, 8'h02, 1);
        send(1, 2, 8'h10, 1);
        send(2, 2, 8'h20, 1);
        send(3, 2, 8'h30, 1);
        expect_bytes(8'h00, 2);
        expect_bytes(8'h10, 2);
        expect_bytes(8'h20, 2);
        expect_bytes(8'h30, 2);
        expect_bytes(8'h02, 2);
        foreach (gexp_q[i]) gexp_q.delete(i);
        gexp_q.push_back(0); gexp_q.push_back(1); gexp_q.push_back(2);
        gexp_q.push_back(3); gexp_q.push_back(0);
        drain(200);

        // Burst limit: source 1 streams 10 bytes without last, source 2 has two messages.
        do_reset();
        send(1, 10, 8'h10, 0);
        send(2, 2, 8'h20, 1);
        send(2, 2, 8'h22, 1);
        expect_bytes(8'h10, 4);
        expect_bytes(8'h20, 2);
        expect_bytes(8'h14, 4);
        expect_bytes(8'h22, 2);
        expect_bytes(8'h18, 2);
        gexp_q.push_back(1); gexp_q.push_back(2); gexp_q.push_back(1);
        gexp_q.push_back(2); gexp_q.push_back(1);
        drain(300);
        check("burst_tail_timeout", 32'(to_cnt), 1);

        // Timeout after one byte, then back-pressure must not time out.
        do_reset();
        send(3, 1, 8'h3A, 0);
        expect_bytes(8'h3A, 1);
        gexp_q.push_back(3);
        drain(100);
        check("to_count", 32'(to_cnt), 1);
        check("to_delay", 32'(to_cyc - acc_cyc), IDLE_TO + 1);
        to_cnt  = 0;
        tx_mode = 1;
        send(3, 2, 8'h3B, 1);
        expect_bytes(8'h3B, 2);
        gexp_q.push_back(3);
        run(24);
        check("stall_no_to", 32'(to_cnt), 0);
        check("stall_lock", 32'(grant_vld), 1);
        tx_mode = 0;
        drain(50);

        // 16-byte message under random tx_ready; splits into four bursts.
        do_reset();
        tx_mode = 2;
        send(0, 16, 8'hA0, 1);
        expect_bytes(8'hA0, 16);
        repeat (4) gexp_q.push_back(0);
        drain(600);
        check("bp_bytes", 32'(tx_hs_n), 16);
        tx_mode = 0;

        // Asynchronous reset while locked with a byte held in the tx register.
        do_reset();
        tx_mode = 1;
        send(2, 3, 8'h50, 0);
        gexp_q.push_back(2);
        run(4);
        check("pre_rst_txv", 32'(tx_valid), 1);
        check("pre_rst_gvld", 32'(grant_vld), 1);
        #3 reset_n = 1'b0;
        #1;
        check_reset_vals();
        flush();
        @(negedge mclk);
        reset_n = 1'b1;
        tx_mode = 0;
        send(2, 1, 8'h60, 1);
        send(0, 1, 8'h61, 1);
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h60);
        gexp_q.push_back(0);
        gexp_q.push_back(2);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
